// File: rtl/key_pulse_gen.sv
// key_pulse_gen: synchronises and debounces the UP/DOWN/MODE board keys
// (bit 0 = UP, bit 1 = DOWN, bit 2 = MODE), exports the debounced levels
// and emits single-cycle press pulses for the music box.
// Optional build macro KEY_REPEAT_EN adds auto-repeat pulses on UP/DOWN
// while they stay held; MODE never repeats.
module key_pulse_gen #(
    parameter int DB_CYCLES     = 240000,
    parameter int CNT_W         = 24,
    parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 1200000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] key_n_in,
    output logic [2:0] button_status,
    output logic [2:0] key_level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reject configurations the counters cannot represent.
    if ((DB_CYCLES < 2) || (((DB_CYCLES - 1) >> CNT_W) != 0) ||
        (REPEAT_DELAY < 1) || (((REPEAT_DELAY - 1) >> CNT_W) != 0) ||
        (REPEAT_PERIOD < 1) || (((REPEAT_PERIOD - 1) >> CNT_W) != 0)) begin : g_bad_params
        $error("key_pulse_gen: parameter out of range for CNT_W");
    end

    // Raw-polarity (active-low) synchroniser and debounced state.
    logic             run;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable_n;
    logic [2:0]       stable_n_nxt;
    logic [CNT_W-1:0] db_cnt     [3];
    logic [CNT_W-1:0] db_cnt_nxt [3];
    logic [2:0]       press_evt;
    logic [2:0]       release_evt;
    logic [2:0]       pulse_nxt;

    // Two-flop synchroniser; the first edge after reset release keeps the
    // released value so a key held through reset is sampled one cycle later.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            run   <= 1'b0;
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            run   <= 1'b1;
            if (run) begin
                sync1 <= key_n_in;
            end
            sync2 <= sync1;
        end
    end

    // Per-key debounce: count consecutive disagreeing samples, commit on the
    // DB_CYCLES-th one, clear the count on any agreeing sample.
    always_comb begin
        stable_n_nxt = stable_n;
        press_evt    = 3'b000;
        release_evt  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            db_cnt_nxt[i] = '0;
            if (sync2[i] != stable_n[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_n_nxt[i] = sync2[i];
                    press_evt[i]    = ~sync2[i];
                    release_evt[i]  = sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stable_n <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_n <= stable_n_nxt;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rpt_phase = 0 while waiting out the initial delay, 1 once in the
    // periodic phase; the counter restarts at every emitted pulse.
    logic [CNT_W-1:0] rpt_cnt [2];
    logic [1:0]       rpt_phase;
    logic [1:0]       rpt_fire;

    // A repeat fires while the key stays pressed; a release on the same
    // edge suppresses it.
    always_comb begin
        rpt_fire = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rpt_fire[i] = key_level[i] && !release_evt[i] &&
                          (rpt_phase[i] ? (rpt_cnt[i] == RP_LAST)
                                        : (rpt_cnt[i] == RD_LAST));
        end
    end

    // Repeat timers for UP/DOWN, restarted on press, cleared on release.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rpt_phase <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (press_evt[i] || release_evt[i] || !key_level[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_phase[i] <= 1'b0;
                end else if (rpt_fire[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_phase[i] <= 1'b1;
                end else begin
                    rpt_cnt[i]   <= rpt_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign pulse_nxt = press_evt | {1'b0, rpt_fire};
`else
    assign pulse_nxt = press_evt;
`endif

    // Registered outputs: level follows the committed state, pulses are
    // launched on the same edge the level rises.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            button_status <= 3'b000;
            key_level     <= 3'b000;
        end else begin
            button_status <= pulse_nxt;
            key_level     <= ~stable_n_nxt;
        end
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed scenarios plus randomized key activity,
// compared cycle by cycle against a sample-window reference model.
module tb_key_pulse_gen;

    localparam int DB  = 8;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int CW  = 8;
    localparam int W   = 6;

    // Clock / reset
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [2:0] key_n_in = 3'b111;
    logic [2:0] button_status;
    logic [2:0] key_level;

    always #5 clk_in = ~clk_in;

    key_pulse_gen #(
        .DB_CYCLES    (DB),
        .CNT_W        (CW),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .key_n_in     (key_n_in),
        .button_status(button_status),
        .key_level    (key_level)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           edge_n = 0;

    // Reference model state: per-key history of pressed samples (bit 0 is
    // the newest edge), current debounced level and press edge.
    logic [31:0]  hist [3];
    logic [2:0]   mdl_level = 3'b000;
    int           press_edge [3];
    bit           first_after_rst = 1'b0;

    // Observation bookkeeping for directed checks.
    int           pulse_cnt  [3];
    int           pulse_edge [3];
    int           fall_edge  [3];
    int           cnt_101 = 0;
    logic [2:0]   prev_level = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Level flips when the DB samples taken two or more edges ago all show
    // the opposite level; a press starts the repeat schedule.
    task automatic model_step();
        logic [31:0] mask;
        logic [31:0] win;
        logic [2:0]  pulse;
        int          age;
        mask  = (32'd1 << DB) - 32'd1;
        pulse = 3'b000;
        edge_n++;
        if (rst_in) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            mdl_level       = 3'b000;
            first_after_rst = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                hist[i] = {hist[i][30:0], first_after_rst ? 1'b0 : ~key_n_in[i]};
                win = (hist[i] >> 2) & mask;
                if (win == (mdl_level[i] ? 32'd0 : mask)) begin
                    mdl_level[i] = ~mdl_level[i];
                    if (mdl_level[i]) begin
                        pulse[i]      = 1'b1;
                        press_edge[i] = edge_n;
                    end
                end else if (mdl_level[i]) begin
                    age = edge_n - press_edge[i];
`ifdef KEY_REPEAT_EN
                    if (i < 2 && (age == RD || (age > RD && (age - RD) % RP == 0)))
                        pulse[i] = 1'b1;
`else
                    age = age + 0;
`endif
                end
            end
            first_after_rst = 1'b0;
        end
        exp_q.push_back({mdl_level, pulse});
    endtask

    task automatic score();
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("key_level", {29'd0, key_level}, {29'd0, exp[5:3]});
            check("button_status", {29'd0, button_status}, {29'd0, exp[2:0]});
        end
        for (int i = 0; i < 3; i++) begin
            if (button_status[i] === 1'b1) begin
                pulse_cnt[i]++;
                pulse_edge[i] = edge_n;
            end
            if (prev_level[i] === 1'b1 && key_level[i] === 1'b0) fall_edge[i] = edge_n;
        end
        if (button_status === 3'b101) cnt_101++;
        prev_level = key_level;
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        score();
    endtask

    task automatic drive(input logic [2:0] pressed, input int cycles);
        key_n_in = ~pressed;
        for (int c = 0; c < cycles; c++) tick();
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) begin
            pulse_cnt[i]  = 0;
            pulse_edge[i] = -1000;
            fall_edge[i]  = -1000;
        end
        cnt_101 = 0;
    endtask

    int k;
    int m;
    int r;
    int run_len [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            hist[i]       = '0;
            press_edge[i] = 0;
        end
        clear_obs();

        // 1: reset with DOWN held
        rst_in   = 1'b1;
        key_n_in = 3'b101;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_status", {29'd0, button_status}, 32'd0);
            check("rst_level", {29'd0, key_level}, 32'd0);
        end
        rst_in = 1'b0;
        drive(3'b010, 15);
        drive(3'b000, 20);

        // 2: UP press and release latency
        clear_obs();
        k = edge_n + 1;
        drive(3'b001, 30);
        m = edge_n + 1;
        drive(3'b000, 20);
        check("up_press_lat", pulse_edge[0] - k, 32'd9);
        check("up_rel_lat", fall_edge[0] - m, 32'd9);
        check("up_pulses", pulse_cnt[0], 32'd1);

        // 3: DOWN bounce then steady press
        clear_obs();
        drive(3'b010, 5);
        drive(3'b000, 3);
        drive(3'b010, 5);
        drive(3'b000, 2);
        k = edge_n + 1;
        drive(3'b010, 20);
        drive(3'b000, 20);
        check("bounce_lat", pulse_edge[1] - k, 32'd9);
        check("bounce_pulses", pulse_cnt[1], 32'd1);

        // 4: UP and MODE together
        clear_obs();
        k = edge_n + 1;
        drive(3'b101, 20);
        check("dual_level", {29'd0, key_level}, 32'd5);
        drive(3'b000, 20);
        check("dual_101", cnt_101, 32'd1);
        check("dual_lat", pulse_edge[2] - k, 32'd9);

        // 5: MODE held through a mid-count reset
        clear_obs();
        drive(3'b100, 7);
        rst_in = 1'b1;
        tick();
        check("midrst_status", {29'd0, button_status}, 32'd0);
        tick();
        check("midrst_level", {29'd0, key_level}, 32'd0);
        rst_in = 1'b0;
        r = edge_n + 1;
        drive(3'b100, 20);
        drive(3'b000, 20);
        check("rst_hold_lat", pulse_edge[2] - r, 32'd10);
        check("rst_hold_pulses", pulse_cnt[2], 32'd1);

        // 6: DOWN and MODE held long
        clear_obs();
        drive(3'b110, 109);
        drive(3'b000, 20);
`ifdef KEY_REPEAT_EN
        check("repeat_down", pulse_cnt[1], 32'd8);
`else
        check("repeat_down", pulse_cnt[1], 32'd1);
`endif
        check("repeat_mode", pulse_cnt[2], 32'd1);

        // Randomized key activity with occasional resets
        for (int i = 0; i < 3; i++) run_len[i] = $urandom_range(1, 12);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                run_len[i]--;
                if (run_len[i] <= 0) begin
                    key_n_in[i] = ~key_n_in[i];
                    run_len[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 90)
                                                              : $urandom_range(1, 12);
                end
            end
            rst_in = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst_in = 1'b0;
        drive(3'b000, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
